// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - queued tone player driving an audio DAC register bus
// Optional inter-note silence (volume-0 write plus GAP_TICKS wait) is enabled by defining TONE_SEQ_GAP_EN.
module tone_sequencer #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] NoteFreq,
    input  logic [7:0]  NoteVol,
    input  logic [11:0] NoteDur,
    input  logic        Push,
    input  logic        Start,
    input  logic        Abort,
    output logic        Full,
    output logic [3:0]  Count,
    output logic        Busy,
    output logic        Done,
    output logic [3:0]  DacAddr,
    output logic [15:0] DacDataWr,
    output logic        DacEn,
    output logic        DacWr
);
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [3:0] ADDR_VOL  = 4'd0;
    localparam logic [3:0] ADDR_FREQ = 4'd1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WR_FREQ,
        WR_VOL,
        PLAY,
        STOP
`ifdef TONE_SEQ_GAP_EN
        ,
        GAP_WR,
        GAP
`endif
    } state_t;

    state_t state, stateNext;

    logic [35:0] fifoMem [8];
    logic [2:0]  wrPtr, rdPtr;
    logic [3:0]  count;
    logic        pushOk, pop;

    logic [15:0] noteFreqQ;
    logic [7:0]  noteVolQ;
    logic [11:0] noteDurQ;

    logic [PRESC_W-1:0] presc;
    logic [15:0]        tickCnt, tickTarget;
    logic               timedState, periodDone, playEnd;

    assign Full   = (count == 4'd8);
    assign Count  = count;
    assign Busy   = (state != IDLE);
    assign Done   = (state == STOP);
    assign pushOk = Push && !Full;
    assign pop    = (state == LOAD);

    // Abort flushes and wins over any push or pop in the same cycle
    always_ff @(posedge Clk) begin
        if (Reset || Abort) begin
            wrPtr <= 3'd0;
            rdPtr <= 3'd0;
            count <= 4'd0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 3'd1;
            if (pop)    rdPtr <= rdPtr + 3'd1;
            count <= count + {3'b000, pushOk} - {3'b000, pop};
        end
    end

    always_ff @(posedge Clk) begin
        if (pushOk) fifoMem[wrPtr] <= {NoteFreq, NoteVol, NoteDur};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            noteFreqQ <= 16'd0;
            noteVolQ  <= 8'd0;
            noteDurQ  <= 12'd0;
        end else if (state == LOAD) begin
            {noteFreqQ, noteVolQ, noteDurQ} <= fifoMem[rdPtr];
        end
    end

    always_comb begin
        timedState = (state == PLAY);
`ifdef TONE_SEQ_GAP_EN
        if (state == GAP) timedState = 1'b1;
`endif
    end

    // PLAY and GAP share one prescaler/tick counter pair, cleared whenever the state changes
    assign tickTarget = (state == PLAY) ? {4'h0, noteDurQ} : 16'(GAP_TICKS);
    assign periodDone = (presc == PRESC_LAST) && (tickCnt == tickTarget - 16'd1);
    assign playEnd    = (noteDurQ == 12'd0) || periodDone;

    always_ff @(posedge Clk) begin
        if (Reset || !timedState || (stateNext != state)) begin
            presc   <= '0;
            tickCnt <= 16'd0;
        end else if (presc == PRESC_LAST) begin
            presc   <= '0;
            tickCnt <= tickCnt + 16'd1;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Start && (count != 4'd0) && !Abort) stateNext = LOAD;
            LOAD:    stateNext = WR_FREQ;
            WR_FREQ: stateNext = WR_VOL;
            WR_VOL:  stateNext = PLAY;
            PLAY: begin
                if (playEnd) begin
                    if (count != 4'd0) begin
`ifdef TONE_SEQ_GAP_EN
                        stateNext = GAP_WR;
`else
                        stateNext = LOAD;
`endif
                    end else begin
                        stateNext = STOP;
                    end
                end
            end
`ifdef TONE_SEQ_GAP_EN
            GAP_WR:  stateNext = GAP;
            GAP:     if (periodDone) stateNext = LOAD;
`endif
            STOP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (Abort && (state != IDLE) && (state != STOP)) stateNext = STOP;
    end

    // STOP and GAP_WR both write volume 0, which also returns the DAC to its wave path
    always_comb begin
        DacEn     = 1'b0;
        DacWr     = 1'b0;
        DacAddr   = 4'd0;
        DacDataWr = 16'd0;
        case (state)
            WR_FREQ: begin
                DacEn     = 1'b1;
                DacWr     = 1'b1;
                DacAddr   = ADDR_FREQ;
                DacDataWr = noteFreqQ;
            end
            WR_VOL: begin
                DacEn     = 1'b1;
                DacWr     = 1'b1;
                DacAddr   = ADDR_VOL;
                DacDataWr = {8'h00, noteVolQ};
            end
`ifdef TONE_SEQ_GAP_EN
            GAP_WR: begin
                DacEn = 1'b1;
                DacWr = 1'b1;
            end
`endif
            STOP: begin
                DacEn = 1'b1;
                DacWr = 1'b1;
            end
            default: begin
                DacEn = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer
// Follows TONE_SEQ_GAP_EN so the same bench covers both builds.
module tb_tone_sequencer;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 2;
`ifdef TONE_SEQ_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] NoteFreq = 16'd0;
    logic [7:0]  NoteVol = 8'd0;
    logic [11:0] NoteDur = 12'd0;
    logic        Push = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic        Full, Busy, Done, DacEn, DacWr;
    logic [3:0]  Count, DacAddr;
    logic [15:0] DacDataWr;

    tone_sequencer #(.TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
        .Clk(Clk), .Reset(Reset), .NoteFreq(NoteFreq), .NoteVol(NoteVol), .NoteDur(NoteDur),
        .Push(Push), .Start(Start), .Abort(Abort), .Full(Full), .Count(Count), .Busy(Busy),
        .Done(Done), .DacAddr(DacAddr), .DacDataWr(DacDataWr), .DacEn(DacEn), .DacWr(DacWr)
    );

    always #5 Clk = ~Clk;

    typedef struct { int cyc; logic done; logic en; logic wr; logic [3:0] addr; logic [15:0] data; } ev_t;
    typedef struct { logic [15:0] freq; logic [7:0] vol; logic [11:0] dur; } note_t;
    typedef struct { logic [15:0] freq; logic [7:0] vol; logic [11:0] dur; int stopOff; } vec_t;

    ev_t   seenAll[$], seenQ[$], expQ[$];
    int    busyAll[$];
    note_t modelQ[$];
    ev_t   monEv;
    int    cyc = 0;
    int    nChecks = 0;
    int    nFails = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (DacEn || DacWr || Done || (DacAddr != 4'd0) || (DacDataWr != 16'd0)) begin
            monEv.cyc  = cyc;
            monEv.done = Done;
            monEv.en   = DacEn;
            monEv.wr   = DacWr;
            monEv.addr = DacAddr;
            monEv.data = DacDataWr;
            seenAll.push_back(monEv);
        end
        if (Busy) busyAll.push_back(cyc);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] packEv(input ev_t e);
        return {e.done, e.en, e.wr, e.addr, e.data};
    endfunction

    function automatic ev_t mkWrite(input int c, input logic dn, input logic [3:0] a, input logic [15:0] d);
        ev_t e;
        e.cyc = c; e.done = dn; e.en = 1'b1; e.wr = 1'b1; e.addr = a; e.data = d;
        return e;
    endfunction

    task automatic collect(input int fromCyc);
        seenQ.delete();
        foreach (seenAll[i]) if (seenAll[i].cyc >= fromCyc) seenQ.push_back(seenAll[i]);
    endtask

    task automatic busyStats(input int fromCyc, output int cnt, output int first);
        cnt = 0;
        first = -1;
        foreach (busyAll[i]) begin
            if (busyAll[i] >= fromCyc) begin
                if (cnt == 0) first = busyAll[i];
                cnt++;
            end
        end
    endtask

    // Timeline of DAC writes computed from the note list: Start at n0, LOAD at n0+1,
    // freq/vol writes follow, PLAY lasts max(1, dur*TICK_DIV), then next note, gap or STOP.
    task automatic buildExpected(input int n0, input int abortAt, output int stopCyc);
        int t, len, endc;
        expQ.delete();
        stopCyc = n0;
        if (modelQ.size() == 0) return;
        t = n0 + 1;
        for (int i = 0; i < modelQ.size(); i++) begin
            expQ.push_back(mkWrite(t + 1, 1'b0, 4'd1, modelQ[i].freq));
            expQ.push_back(mkWrite(t + 2, 1'b0, 4'd0, {8'h00, modelQ[i].vol}));
            len  = (modelQ[i].dur == 12'd0) ? 1 : int'(modelQ[i].dur) * TICK_DIV;
            endc = t + 2 + len;
            if (i == modelQ.size() - 1) begin
                stopCyc = endc + 1;
            end else if (GAP_EN) begin
                expQ.push_back(mkWrite(endc + 1, 1'b0, 4'd0, 16'd0));
                t = endc + 2 + GAP_TICKS * TICK_DIV;
            end else begin
                t = endc + 1;
            end
        end
        expQ.push_back(mkWrite(stopCyc, 1'b1, 4'd0, 16'd0));
        if (abortAt > n0 && abortAt < stopCyc) begin
            while (expQ.size() > 0 && expQ[$].cyc > abortAt) void'(expQ.pop_back());
            stopCyc = abortAt + 1;
            expQ.push_back(mkWrite(stopCyc, 1'b1, 4'd0, 16'd0));
        end
    endtask

    task automatic compareEvents(input string name);
        check($sformatf("%s event count", name), seenQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < seenQ.size(); i++) begin
            check($sformatf("%s ev%0d cycle", name, i), seenQ[i].cyc, expQ[i].cyc);
            check($sformatf("%s ev%0d {done,en,wr,addr,data}", name, i), packEv(seenQ[i]), packEv(expQ[i]));
        end
    endtask

    task automatic pushNote(input note_t n);
        NoteFreq = n.freq;
        NoteVol  = n.vol;
        NoteDur  = n.dur;
        Push     = 1'b1;
        step();
        Push     = 1'b0;
    endtask

    function automatic note_t randNote();
        note_t n;
        n.freq = 16'($urandom);
        n.vol  = 8'($urandom);
        n.dur  = 12'($urandom_range(0, 3));
        return n;
    endfunction

    // abortOff: -1 no abort, -2 random abort cycle, otherwise Abort at n0+abortOff
    task automatic runScenario(input string name, input int nPush, input int abortOff);
        int n0, stopFull, stopCyc, abortAt, bc, bf;
        note_t n;
        modelQ.delete();
        for (int i = 0; i < nPush; i++) begin
            n = randNote();
            pushNote(n);
            if (modelQ.size() < 8) modelQ.push_back(n);
            check($sformatf("%s Count after push %0d", name, i + 1), Count, modelQ.size());
            check($sformatf("%s Full after push %0d", name, i + 1), Full, modelQ.size() == 8);
        end
        n0 = cyc;
        buildExpected(n0, -1, stopFull);
        abortAt = -1;
        if (abortOff == -2 && stopFull > n0) abortAt = n0 + 1 + $urandom_range(0, stopFull - n0 - 1);
        else if (abortOff >= 0) abortAt = n0 + abortOff;
        buildExpected(n0, abortAt, stopCyc);
        Start = 1'b1;
        step();
        Start = 1'b0;
        while (cyc <= stopCyc + 3) begin
            Abort = (cyc == abortAt);
            step();
        end
        Abort = 1'b0;
        collect(n0);
        compareEvents(name);
        busyStats(n0, bc, bf);
        check($sformatf("%s busy cycles", name), bc, stopCyc - n0);
        if (stopCyc > n0) check($sformatf("%s first busy cycle", name), bf, n0 + 1);
        check($sformatf("%s final Count", name), Count, 0);
        check($sformatf("%s final Busy", name), Busy, 0);
    endtask

    initial begin
        int n0, stopCyc, from;
        vec_t vecs[4];
        note_t nA, nB;

        vecs[0] = '{16'h0100, 8'h40, 12'd3, 16};
        vecs[1] = '{16'hBEEF, 8'hFF, 12'd0, 5};
        vecs[2] = '{16'h1234, 8'h01, 12'd1, 8};
        vecs[3] = '{16'h0001, 8'h80, 12'd2, 12};

        repeat (3) step();
        check("reset Full/Count/Busy/Done", {Full, Count, Busy, Done}, 7'd0);
        check("reset DacEn/DacWr", {DacEn, DacWr}, 2'd0);
        check("reset DacAddr", DacAddr, 4'd0);
        check("reset DacDataWr", DacDataWr, 16'd0);
        Reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            from = cyc;
            nA.freq = vecs[v].freq; nA.vol = vecs[v].vol; nA.dur = vecs[v].dur;
            pushNote(nA);
            n0 = cyc;
            Start = 1'b1;
            step();
            Start = 1'b0;
            repeat (vecs[v].stopOff + 2) step();
            collect(from);
            check($sformatf("vec%0d event count", v), seenQ.size(), 3);
            if (seenQ.size() == 3) begin
                check($sformatf("vec%0d freq write cycle", v), seenQ[0].cyc, n0 + 2);
                check($sformatf("vec%0d freq write", v), packEv(seenQ[0]), {1'b0, 1'b1, 1'b1, 4'd1, vecs[v].freq});
                check($sformatf("vec%0d vol write cycle", v), seenQ[1].cyc, n0 + 3);
                check($sformatf("vec%0d vol write", v), packEv(seenQ[1]), {1'b0, 1'b1, 1'b1, 4'd0, 8'h00, vecs[v].vol});
                check($sformatf("vec%0d stop cycle", v), seenQ[2].cyc, n0 + vecs[v].stopOff);
                check($sformatf("vec%0d stop write", v), packEv(seenQ[2]), {1'b1, 1'b1, 1'b1, 4'd0, 16'h0000});
            end
        end

        from = cyc;
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("start on empty queue Busy", Busy, 0);
        collect(from);
        check("start on empty queue events", seenQ.size(), 0);

        pushNote(randNote());
        pushNote(randNote());
        check("two pushes Count", Count, 2);
        from = cyc;
        NoteFreq = 16'h5555;
        Push  = 1'b1;
        Abort = 1'b1;
        step();
        Push  = 1'b0;
        Abort = 1'b0;
        check("abort over push in IDLE Count", Count, 0);
        repeat (3) step();
        collect(from);
        check("abort in IDLE no Done/writes", seenQ.size(), 0);
        check("abort in IDLE Busy", Busy, 0);

        modelQ.delete();
        nA = randNote(); nA.dur = 12'd3;
        nB = randNote();
        from = cyc;
        pushNote(nA);
        modelQ.push_back(nA);
        n0 = cyc;
        Start = 1'b1;
        step();
        Start = 1'b0;
        while (cyc < n0 + 6) step();
        pushNote(nB);
        modelQ.push_back(nB);
        buildExpected(n0, -1, stopCyc);
        while (cyc <= stopCyc + 3) step();
        collect(from);
        compareEvents("late push");

        nA = randNote(); nA.dur = 12'd3;
        pushNote(nA);
        pushNote(randNote());
        n0 = cyc;
        Start = 1'b1;
        step();
        Start = 1'b0;
        while (cyc < n0 + 6) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        from = cyc;
        check("reset in PLAY Dac outputs", {DacEn, DacWr, DacAddr, DacDataWr}, 22'd0);
        check("reset in PLAY status", {Done, Busy, Full, Count}, 7'd0);
        repeat (20) step();
        collect(from);
        check("reset in PLAY no later writes", seenQ.size(), 0);

        runScenario("nine pushes", 9, -1);
        runScenario("abort in first PLAY", 3, 4);
        for (int k = 0; k < 12; k++) runScenario($sformatf("random%0d", k), $urandom_range(0, 10), -2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL use clock Clk and reset Reset; Reset synchronous, active-high, sampled on posedge Clk.
REQ-002 Parameter TICK_DIV, default 50000, Clk cycles per duration tick (1 ms at 50 MHz); minimum 2.
REQ-003 Parameter GAP_TICKS, default 10, silence ticks between notes; used only with TONE_SEQ_GAP_EN; minimum 1.
REQ-004 Port list:
  Clk  input  1  system clock
  Reset  input  1  synchronous reset
  NoteFreq  input  16  tone half-period code for the audio DAC frequency register
  NoteVol  input  8  tone volume code for the audio DAC volume register
  NoteDur  input  12  note duration in ticks
  Push  input  1  enqueue {NoteFreq, NoteVol, NoteDur}
  Start  input  1  begin playback
  Abort  input  1  stop playback, flush queue
  Full  output  1  queue holds 8 entries
  Count  output  4  queue occupancy, 0..8
  Busy  output  1  FSM not in IDLE
  Done  output  1  one-cycle pulse on playback end
  DacAddr  output  4  audio DAC register address
  DacDataWr  output  16  audio DAC write data
  DacEn  output  1  audio DAC bus enable
  DacWr  output  1  audio DAC write strobe

Function
REQ-005 Queue SHALL be an 8-entry FIFO of 36-bit {freq, vol, dur} entries.
REQ-006 Push with Full=0 SHALL write one entry; Push with Full=1 SHALL be dropped, queue unchanged.
REQ-007 Push and pop in the same cycle SHALL both occur when Full=0; when Full=1, the pop occurs and the push is dropped.
REQ-008 FSM states SHALL be IDLE, LOAD, WR_FREQ, WR_VOL, PLAY, GAP_WR, GAP and STOP.
REQ-009 IDLE: Start=1 with Count>0 SHALL go to LOAD; Start with Count=0 SHALL be ignored; Start outside IDLE SHALL be ignored.
REQ-010 LOAD SHALL latch the head entry, pop it and go to WR_FREQ; one cycle.
REQ-011 WR_FREQ SHALL drive DacEn=1, DacWr=1, DacAddr=1, DacDataWr=freq for one cycle, then go to WR_VOL.
REQ-012 WR_VOL SHALL drive DacEn=1, DacWr=1, DacAddr=0, DacDataWr={8'h00, vol} for one cycle, then go to PLAY.
REQ-013 Outside write cycles, DacEn, DacWr, DacAddr and DacDataWr SHALL all be 0.
REQ-014 PLAY SHALL last dur*TICK_DIV cycles, with the prescaler cleared on entry; dur=0 SHALL last exactly 1 cycle.
REQ-015 PLAY end with Count>0 SHALL go to LOAD, or to GAP_WR per REQ-022; PLAY end with Count=0 SHALL go to STOP.
REQ-016 STOP SHALL write DacAddr=0, DacDataWr=0 (volume 0, returning the DAC to its wave path), pulse Done=1 for that cycle, then go to IDLE.
REQ-017 Start at cycle N SHALL produce the first freq write at N+2, the vol write at N+3 and PLAY from N+4.
REQ-018 Abort=1 in any non-IDLE state except STOP SHALL flush the queue (Count=0) and go to STOP the next cycle; Abort in IDLE SHALL flush only, with no Done.
REQ-019 Abort SHALL have priority over Push in the same cycle.
REQ-020 Pushes during playback SHALL be accepted and played in order.
REQ-021 Busy SHALL be 1 in every state except IDLE.

Configuration
REQ-022 With macro TONE_SEQ_GAP_EN defined, PLAY end with Count>0 SHALL go to GAP_WR.
  - GAP_WR writes volume 0 (Addr 0, data 0) for one cycle.
  - GAP then waits GAP_TICKS*TICK_DIV cycles before going to LOAD.
  - Abort applies in GAP_WR and GAP.
REQ-023 Without TONE_SEQ_GAP_EN, GAP_WR and GAP SHALL NOT exist, and notes SHALL play back-to-back via LOAD.

Reset
REQ-024 Reset SHALL force IDLE, empty the queue, clear the prescaler and duration counters, and set all outputs to 0 (Full=0, Count=0, Busy=0, Done=0, all Dac outputs 0).
REQ-025 Reset mid-playback SHALL NOT issue a STOP write.

Verification (TICK_DIV=4, GAP_TICKS=2)
REQ-026 Push {0x0100,0x40,3}, then Start at cycle N -> writes (1,0x0100) at N+2 and (0,0x0040) at N+3, PLAY for 12 cycles, STOP write (0,0x0000) with Done at N+16.
REQ-027 Push 9 entries -> Full=1 and Count=8 after the 8th push; the 9th entry is dropped and 8 notes play in push order.
REQ-028 Push a note with dur=0, then Start -> PLAY lasts 1 cycle, then STOP.
REQ-029 Push 3 notes, then Start, then Abort during PLAY of note 1 -> next cycle STOP write and Done, Count=0, no further freq writes.
REQ-030 With TONE_SEQ_GAP_EN, play 2 notes -> a volume-0 write and 8 silent cycles between the vol write of note 1's end and the LOAD of note 2; without the macro, LOAD follows PLAY directly.
REQ-031 Reset asserted during PLAY -> next cycle all outputs 0, Count=0, and no Dac write is issued.
